// File: rtl/keypad_display_initiator_pkg.sv
// Shared constants and types for the keypad/display bus initiator.
//   - key code values with special meaning (clear, backspace)
//   - bit positions inside the keypad status word
//   - default bus addresses of the keypad and display registers
//   - FSM state encoding
package keypad_display_initiator_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;

    localparam int VALID_BIT = 4;
    localparam int CODE_MSB  = 3;

    localparam logic [3:0] KEY_ADDR_DEFAULT  = 4'h0;
    localparam logic [3:0] DISP_ADDR_DEFAULT = 4'h4;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_RD,
        ST_RD_WAIT,
        ST_CAP,
        ST_WR
    } state_e;

    // Codes 0x0-0xB do something to the buffer; 0xC-0xF are ignored.
    function automatic logic is_key_code(input logic [3:0] code);
        return code <= KEY_BACK;
    endfunction

endpackage

// File: rtl/keypad_display_initiator_if.sv
// Peripheral bus between an initiator and the peripheral controller.
//   address     : 4-bit register address (initiator -> responder)
//   dout        : 32-bit write data      (initiator -> responder)
//   writeEnable : one-cycle write strobe (initiator -> responder)
//   din         : 32-bit registered read data (responder -> initiator)
interface keypad_display_initiator_if;
    logic [3:0]  address;
    logic [31:0] dout;
    logic        writeEnable;
    logic [31:0] din;

    modport master (output address, output dout, output writeEnable, input din);
    modport slave  (input address, input dout, input writeEnable, output din);
endinterface

// File: rtl/keypad_display_initiator_bcd_entry_buffer.sv
// 8-digit BCD entry buffer.
//   clk, reset : clock, asynchronous active-low reset
//   accept     : apply code this cycle
//   code       : key code (0-9 digit, KEY_CLEAR, KEY_BACK; others leave entry alone)
//   entry      : registered buffer, digit0 = [3:0] = most recent
//   entry_nxt  : value entry would take if code were accepted now
module keypad_display_initiator_bcd_entry_buffer
    import keypad_display_initiator_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic [3:0]  code,
    output logic [31:0] entry,
    output logic [31:0] entry_nxt
);

    logic [31:0] entry_q, entry_d;

    always_comb begin
        entry_nxt = entry_q;
        if (code <= 4'd9) begin
            entry_nxt = {entry_q[27:0], code};
        end else if (code == KEY_CLEAR) begin
            entry_nxt = '0;
        end else if (code == KEY_BACK) begin
            entry_nxt = {4'h0, entry_q[31:4]};
        end
        entry_d = accept ? entry_nxt : entry_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) entry_q <= '0;
        else        entry_q <= entry_d;
    end

    assign entry = entry_q;

endmodule

// File: rtl/keypad_display_initiator.sv
// Bus initiator that polls the keypad register, edge-detects key presses,
// maintains an 8-digit BCD entry buffer and writes it to the display
// register whenever it changes.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : peripheral bus, master side (address/dout/writeEnable out, din in)
//   entry      : current buffer contents
//   key_event  : one-cycle pulse per accepted key press
module keypad_display_initiator
    import keypad_display_initiator_pkg::*;
#(
    parameter int         POLL_CYCLES  = 1000,
    parameter logic [3:0] KEY_ADDR     = KEY_ADDR_DEFAULT,
    parameter logic [3:0] DISP_ADDR    = DISP_ADDR_DEFAULT,
    parameter int         READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    keypad_display_initiator_if.master    bus,
    output logic [31:0]                   entry,
    output logic                          key_event
);

    // One counter serves both the poll interval and the read-latency wait.
    localparam int CNT_MAX = (POLL_CYCLES > READ_LATENCY) ? POLL_CYCLES : READ_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               prev_valid_q, prev_valid_d;
    logic [3:0]         address_q, address_d;
    logic [31:0]        dout_q, dout_d;
    logic               we_q, we_d;
    logic               key_event_q, key_event_d;

    logic               key_valid;
    logic [3:0]         key_code;
    logic               accept;
    logic [31:0]        entry_nxt;
    logic               unused_din;

    assign key_valid  = bus.din[VALID_BIT];
    assign key_code   = bus.din[CODE_MSB:0];
    assign unused_din = ^bus.din[31:VALID_BIT+1];

    // Rising edge of valid only, so a held key counts once.
    assign accept = (state_q == ST_CAP) && key_valid && !prev_valid_q && is_key_code(key_code);

    keypad_display_initiator_bcd_entry_buffer u_bcd_entry_buffer (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept),
        .code      (key_code),
        .entry     (entry),
        .entry_nxt (entry_nxt)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        prev_valid_d = prev_valid_q;
        address_d    = KEY_ADDR;
        dout_d       = dout_q;
        we_d         = 1'b0;
        key_event_d  = 1'b0;
        unique case (state_q)
            ST_WAIT: begin
                if (cnt_q == CNT_W'(POLL_CYCLES - 1)) begin
                    state_d = ST_RD;
                    cnt_d   = '0;
                end
            end
            ST_RD: begin
                cnt_d   = '0;
                state_d = (READ_LATENCY == 0) ? ST_CAP : ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
                    state_d = ST_CAP;
                    cnt_d   = '0;
                end
            end
            ST_CAP: begin
                prev_valid_d = key_valid;
                key_event_d  = accept;
                cnt_d        = '0;
                // Outputs are registered, so the write is set up here and
                // appears on the bus during the WR cycle itself.
                if (accept && (entry_nxt != entry)) begin
                    state_d   = ST_WR;
                    address_d = DISP_ADDR;
                    dout_d    = entry_nxt;
                    we_d      = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WR: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_WAIT;
            cnt_q        <= '0;
            prev_valid_q <= 1'b0;
            address_q    <= KEY_ADDR;
            dout_q       <= '0;
            we_q         <= 1'b0;
            key_event_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_valid_q <= prev_valid_d;
            address_q    <= address_d;
            dout_q       <= dout_d;
            we_q         <= we_d;
            key_event_q  <= key_event_d;
        end
    end

    assign bus.address     = address_q;
    assign bus.dout        = dout_q;
    assign bus.writeEnable = we_q;
    assign key_event       = key_event_q;

endmodule

// File: tb/tb_keypad_display_initiator.sv
// Self-checking bench for keypad_display_initiator. A poll-schedule model
// predicts entry, key_event and the display writes cycle by cycle; directed
// literal checks pin the model at the interesting points.
module tb_keypad_display_initiator;

    localparam int P  = 8;
    localparam int RL = 1;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] entry;
    logic        key_event;

    always #5 clk = ~clk;

    keypad_display_initiator_if bus_if ();

    keypad_display_initiator #(
        .POLL_CYCLES  (P),
        .KEY_ADDR     (4'h0),
        .DISP_ADDR    (4'h4),
        .READ_LATENCY (RL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if.master),
        .entry     (entry),
        .key_event (key_event)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] apply_key(input logic [31:0] e, input logic [3:0] c);
        if (c <= 4'd9)       return (e << 4) | 32'(c);
        else if (c == 4'hA)  return 32'h0;
        else                 return e >> 4;
    endfunction

    int          m_k        = 0;          // index of the current cycle since reset release
    int          m_next_cap = P + RL + 1; // cycle whose closing edge samples din
    int          m_caps     = 0;          // captures since start of sim
    logic        m_prev     = 1'b0;
    logic [31:0] m_entry    = '0;
    logic [31:0] m_wdata    = '0;
    logic        m_we       = 1'b0;
    logic        m_kev      = 1'b0;
    logic [31:0] m_w, m_nv;
    logic        m_acc, m_wr;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_k = 0; m_next_cap = P + RL + 1; m_prev = 1'b0;
            m_entry = '0; m_we = 1'b0; m_kev = 1'b0;
        end else begin
            m_we = 1'b0; m_kev = 1'b0; m_wr = 1'b0;
            if (m_k == m_next_cap) begin
                m_w   = bus_if.din;
                m_acc = m_w[4] && !m_prev && (m_w[3:0] <= 4'hB);
                m_prev = m_w[4];
                if (m_acc) begin
                    m_nv  = apply_key(m_entry, m_w[3:0]);
                    m_kev = 1'b1;
                    if (m_nv != m_entry) begin
                        m_we = 1'b1; m_wdata = m_nv; m_wr = 1'b1;
                    end
                    m_entry = m_nv;
                end
                m_caps++;
                // wait P cycles, one RD, RL wait cycles, one CAP; plus WR if any
                m_next_cap = m_k + 1 + P + RL + 1 + (m_wr ? 1 : 0);
            end
            m_k++;
        end
    end

    // ---------------- per-cycle compare ----------------
    int n_wr  = 0;
    int n_kev = 0;

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_we",   32'(bus_if.writeEnable), 32'h0);
            check("rst_addr", 32'(bus_if.address),     32'h0);
            check("rst_entry", entry,                  32'h0);
            check("rst_kev",  32'(key_event),          32'h0);
        end else begin
            check("entry", entry,                       m_entry);
            check("kev",   32'(key_event),              32'(m_kev));
            check("we",    32'(bus_if.writeEnable),     32'(m_we));
            check("addr",  32'(bus_if.address),        m_we ? 32'h4 : 32'h0);
            if (m_we) check("wdata", bus_if.dout, m_wdata);
            if (bus_if.writeEnable) n_wr++;
            if (key_event)          n_kev++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_caps(input int n);
        int tgt;
        tgt = m_caps + n;
        for (int i = 0; i < n * 20 && m_caps < tgt; i++) @(negedge clk);
        @(negedge clk);
        #1;
        if (m_caps < tgt) begin
            checks++; failures++;
            $display("FAIL poll_timeout caps=%0d expected=%0d", m_caps, tgt);
        end
    endtask

    task automatic press(input logic [31:0] w, input int n);
        bus_if.din = w;
        wait_caps(n);
    endtask

    int wr0, kev0;
    bit seen;

    initial begin
        bus_if.din = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_dout",  bus_if.dout, 32'h0);
        check("reset_entry", entry,       32'h0);
        reset = 1'b1;

        // idle polls: nothing happens
        wait_caps(3);
        check("idle_writes", 32'(n_wr), 32'd0);
        check("idle_entry",  entry,     32'h0);

        // 0x13, 0x00, 0x17
        press(32'h13, 1);
        check("first_digit", entry,     32'h3);
        check("first_wr",    32'(n_wr), 32'd1);
        press(32'h00, 1);
        press(32'h17, 1);
        check("second_digit", entry,     32'h37);
        check("second_wr",    32'(n_wr), 32'd2);
        press(32'h00, 1);

        // clear, then hold 5 for five polls
        press(32'h1A, 1);
        press(32'h00, 1);
        wr0 = n_wr; kev0 = n_kev;
        press(32'h15, 5);
        check("hold_entry", entry,            32'h5);
        check("hold_kev",   32'(n_kev - kev0), 32'd1);
        check("hold_wr",    32'(n_wr - wr0),   32'd1);
        press(32'h00, 1);

        // digits 1..9 with releases
        for (int d = 1; d <= 9; d++) begin
            press(32'h10 | 32'(d), 1);
            press(32'h00, 1);
        end
        check("nine_digits", entry, 32'h23456789);
        wr0 = n_wr;
        press(32'h1B, 1);
        check("backspace",    entry,          32'h02345678);
        check("backspace_wr", 32'(n_wr - wr0), 32'd1);
        press(32'h00, 1);
        press(32'h1A, 1);
        check("clear",    entry,          32'h0);
        check("clear_wr", 32'(n_wr - wr0), 32'd2);
        press(32'h00, 1);

        // digit 0 into an all-zero buffer: event but no write
        wr0 = n_wr; kev0 = n_kev;
        press(32'h10, 1);
        check("zero_kev", 32'(n_kev - kev0), 32'd1);
        check("zero_wr",  32'(n_wr - wr0),   32'd0);
        press(32'h00, 1);

        // ignored code, and upper bits of the keypad word
        wr0 = n_wr; kev0 = n_kev;
        press(32'h1E, 1);
        press(32'h00, 1);
        // bit 4 of 0xE5 is clear, so this word carries no valid key
        press(32'hFFFFFFE5, 1);
        press(32'h00, 1);
        check("ignored_kev", 32'(n_kev - kev0), 32'd0);
        check("ignored_wr",  32'(n_wr - wr0),   32'd0);
        press(32'hFFFFFFF5, 1);
        check("upper_bits_entry", entry,            32'h5);
        check("upper_bits_kev",   32'(n_kev - kev0), 32'd1);
        press(32'h00, 1);

        // reset landing in the WR cycle
        bus_if.din = 32'h17;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus_if.writeEnable) seen = 1'b1;
        end
        check("wr_seen", 32'(seen), 32'd1);
        reset = 1'b0;
        #1;
        check("async_we_drop",  32'(bus_if.writeEnable), 32'h0);
        check("async_entry",    entry,                   32'h0);
        check("async_addr",     32'(bus_if.address),     32'h0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        wr0 = n_wr;
        wait_caps(1);
        check("resume_entry", entry,          32'h7);
        check("resume_wr",    32'(n_wr - wr0), 32'd1);
        press(32'h00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
